imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set instruction memory depth DEPTH = 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 num_words  input  ADDR_WIDTH+1  number of words to load; sampled only on an accepted start.
REQ-007 byte_valid  input  1  byte_data holds a valid program byte.
REQ-008 byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 we  output  1  instruction-memory write strobe.
REQ-011 waddr  output  32  byte address of the word being written, word aligned.
REQ-012 wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  load in progress; CPU core is held in reset while high.
REQ-014 done  output  1  sticky load-complete flag.
REQ-015 err  output  1  one-cycle pulse on a rejected start.
REQ-016 checksum  output  32  modulo-2^32 sum of all words written in the current load.

Function
REQ-017 FSM SHALL have states IDLE, RECV, WRITE, DONE.
REQ-018 IDLE/DONE + start with 0 < num_words <= DEPTH: latch num_words, clear word index, byte count, checksum and done; go to RECV next cycle.
REQ-019 start with num_words == 0: go directly to DONE with done=1, checksum=0, no writes.
REQ-020 start with num_words > DEPTH: err=1 for one cycle, state, done and checksum unchanged.
REQ-021 start while in RECV or WRITE SHALL be ignored, no err.
REQ-022 byte_ready SHALL be 1 only in RECV; a byte is accepted when byte_valid && byte_ready.
REQ-023 Accepted byte k (k = 0..3 within a word) SHALL be stored in wdata[8k+7:8k].
REQ-024 Acceptance of byte 3 SHALL move the FSM to WRITE on the next edge; byte count wraps to 0.
REQ-025 In WRITE: we=1 for exactly one cycle, waddr = BASE_ADDR + 4*index, wdata = assembled word; checksum += wdata on that edge.
REQ-026 After WRITE: index increments; if index+1 == latched num_words go to DONE, else RECV.
REQ-027 Minimum period is 5 cycles per word (4 RECV + 1 WRITE) with byte_valid held high.
REQ-028 byte_valid low in RECV SHALL stall with no state change; no timeout.
REQ-029 busy SHALL be 1 in RECV and WRITE, 0 otherwise; done SHALL be 1 only in DONE.
REQ-030 we SHALL be 0 outside WRITE; waddr/wdata SHALL hold their last values outside WRITE.
REQ-031 Index arithmetic SHALL be ADDR_WIDTH+1 bits, so num_words == DEPTH loads every word without wrap.

Reset
REQ-032 rst low SHALL force immediately, regardless of clk: state IDLE, byte_ready=0, we=0, waddr=BASE_ADDR, wdata=0, busy=0, done=0, err=0, checksum=0, index and byte count 0.
REQ-033 Reset during RECV or WRITE SHALL discard the partial word; no write is issued after reset assertion.
REQ-034 After rst deasserts, the loader SHALL stay in IDLE until a start.

Verification
REQ-035 start, num_words=2, bytes 13 00 00 00 93 00 10 00 back-to-back -> we at cycles 5 and 10 after RECV entry; waddr 0x0 then 0x4; wdata 0x00000013 then 0x00100093; checksum 0x001000A6; done=1.
REQ-036 num_words=1 with byte_valid toggling every other cycle -> single write of the correct word; byte_ready only in RECV; no byte lost or duplicated.
REQ-037 num_words=0 -> done=1 next cycle, no we pulse; num_words=DEPTH+1 -> one err pulse, state unchanged.
REQ-038 rst low after byte 2 of word 1 -> all outputs at reset values immediately; a new load then writes word 0 at BASE_ADDR correctly.
REQ-039 start asserted mid-load -> ignored, no err, load completes unchanged; num_words=DEPTH -> last waddr BASE_ADDR+4*(DEPTH-1), then done.

Source files
------------

// File: rtl/imem_loader.sv
// Purpose: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: 4 accepted bytes plus 1 write cycle per word (5 cycles minimum); done/err follow start by one edge.
// Backpressure: byte_ready is high only while collecting bytes; byte_valid low simply stalls, with no timeout.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  we,
    output logic [31:0]           waddr,
    output logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // DEPTH needs the extra index bit so a full-memory load is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_WIDTH:0] nwords;
    logic [ADDR_WIDTH:0] idx;
    logic [ADDR_WIDTH:0] idx_inc;
    logic [1:0]          bcnt;
    logic [23:0]         asm_buf;
    logic                idle_like;
    logic                start_ok;
    logic                start_zero;
    logic                start_bad;
    logic                byte_acc;

    // A new start is only honoured once the previous load has finished (or never began).
    assign idle_like  = (state == IDLE) || (state == DONE);
    assign start_zero = idle_like && start && (num_words == '0);
    assign start_ok   = idle_like && start && (num_words != '0) && (num_words <= DEPTH);
    assign start_bad  = idle_like && start && (num_words > DEPTH);
    assign byte_acc   = (state == RECV) && byte_valid;
    assign idx_inc    = idx + IDX_ONE;

    // State register; reset drops straight to IDLE, abandoning any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived strobes.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start_zero) begin
                    state_nxt = DONE;
                end else if (start_ok) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (bcnt == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
                state_nxt = (idx_inc == nwords) ? DONE : RECV;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Load bookkeeping: word count latch, word index and rejected-start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nwords <= '0;
            idx    <= '0;
            err    <= 1'b0;
        end else begin
            err <= start_bad;
            if (start_ok) begin
                nwords <= num_words;
                idx    <= '0;
            end else if (start_zero) begin
                idx    <= '0;
            end else if (state == WRITE) begin
                idx    <= idx_inc;
            end
        end
    end

    // Byte assembly; the write port registers are only loaded on the final byte so they hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt    <= '0;
            asm_buf <= '0;
            waddr   <= BASE_ADDR;
            wdata   <= '0;
        end else begin
            if (start_ok || start_zero) begin
                bcnt <= '0;
            end else if (byte_acc) begin
                bcnt <= bcnt + 2'd1;
                case (bcnt)
                    2'd0: asm_buf[7:0]   <= byte_data;
                    2'd1: asm_buf[15:8]  <= byte_data;
                    2'd2: asm_buf[23:16] <= byte_data;
                    default: begin
                        wdata <= {byte_data, asm_buf};
                        waddr <= BASE_ADDR + (32'(idx) << 2);
                    end
                endcase
            end
        end
    end

    // Running modulo-2^32 sum of every word written in the current load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (start_ok || start_zero) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum + wdata;
        end
    end

endmodule
